// File: rtl/mfp_sdram_arb_if.sv
// Bus bundle between the two requesters, the SDRAM controller FIFOs and the
// arbiter. The arbiter connects through the slave modport; whatever drives
// the requesters and models the FIFOs connects through the master modport.
//
// Handshake semantics:
//   Mx_REQ is level, held with a stable command until a one-cycle Mx_ACK;
//   Mx_RVALID is a one-cycle strobe qualifying Mx_RDATA (no back-pressure);
//   CFIFO_WEN/WFIFO_WEN push one entry and are only raised when the matching
//   WFULL was low while the arbiter was idle; RFIFO_REN pops the show-ahead
//   entry presented while RFIFO_REMPTY is low.
interface mfp_sdram_arb_if;
    logic        M0_REQ;
    logic        M0_WRITE;
    logic [2:0]  M0_SIZE;
    logic [31:0] M0_ADDR;
    logic [31:0] M0_WDATA;
    logic        M0_ACK;
    logic        M0_RVALID;
    logic [31:0] M0_RDATA;

    logic        M1_REQ;
    logic        M1_WRITE;
    logic [2:0]  M1_SIZE;
    logic [31:0] M1_ADDR;
    logic [31:0] M1_WDATA;
    logic        M1_ACK;
    logic        M1_RVALID;
    logic [31:0] M1_RDATA;

    logic        CFIFO_WEN;
    logic [35:0] CFIFO_WDATA;
    logic        CFIFO_WFULL;
    logic        WFIFO_WEN;
    logic [32:0] WFIFO_WDATA;
    logic        WFIFO_WFULL;
    logic        RFIFO_REN;
    logic [32:0] RFIFO_RDATA;
    logic        RFIFO_REMPTY;

    modport slave (
        input  M0_REQ, M0_WRITE, M0_SIZE, M0_ADDR, M0_WDATA,
        output M0_ACK, M0_RVALID, M0_RDATA,
        input  M1_REQ, M1_WRITE, M1_SIZE, M1_ADDR, M1_WDATA,
        output M1_ACK, M1_RVALID, M1_RDATA,
        output CFIFO_WEN, CFIFO_WDATA,
        input  CFIFO_WFULL,
        output WFIFO_WEN, WFIFO_WDATA,
        input  WFIFO_WFULL,
        output RFIFO_REN,
        input  RFIFO_RDATA, RFIFO_REMPTY
    );

    modport master (
        output M0_REQ, M0_WRITE, M0_SIZE, M0_ADDR, M0_WDATA,
        input  M0_ACK, M0_RVALID, M0_RDATA,
        output M1_REQ, M1_WRITE, M1_SIZE, M1_ADDR, M1_WDATA,
        input  M1_ACK, M1_RVALID, M1_RDATA,
        input  CFIFO_WEN, CFIFO_WDATA,
        output CFIFO_WFULL,
        input  WFIFO_WEN, WFIFO_WDATA,
        output WFIFO_WFULL,
        input  RFIFO_REN,
        output RFIFO_RDATA, RFIFO_REMPTY
    );
endinterface

// File: rtl/mfp_sdram_arb.sv
// Two-requester round-robin arbiter in front of the SDRAM controller FIFOs.
// Commands issue at most one per three cycles (IDLE -> ISSUE -> HOLD); read
// data is routed back through an in-order tag queue holding the requester id
// of every outstanding read.
module mfp_sdram_arb #(
    parameter int TAG_DEPTH = 4,
    parameter int TAG_AW    = 2
) (
    input  logic              SDRAM_CLK,
    input  logic              SDRAM_RSTn,
    mfp_sdram_arb_if.slave    bus,
    output logic [1:0]        dbg_state,
    output logic [TAG_AW:0]   dbg_tag_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [TAG_AW:0] TAG_FULL_CNT = (TAG_AW + 1)'(TAG_DEPTH);

    state_t            state;
    logic              rr_ptr;
    logic              grant;
    logic              cmd_write;

    logic              tag_mem [TAG_DEPTH];
    logic [TAG_AW-1:0] tag_wr_ptr;
    logic [TAG_AW-1:0] tag_rd_ptr;
    logic [TAG_AW:0]   tag_count;
    logic              tag_full;
    logic              tag_push;
    logic              tag_pop;
    logic              tag_head;

    logic              elig0;
    logic              elig1;
    logic              win;
    logic              win_write;
    logic [2:0]        win_size;
    logic [31:0]       win_addr;
    logic [31:0]       win_wdata;
    logic              unused_rdata_msb;

    assign tag_full = (tag_count == TAG_FULL_CNT);
    assign tag_head = tag_mem[tag_rd_ptr];
    assign tag_push = (state == S_ISSUE) & ~cmd_write;
    assign tag_pop  = ~bus.RFIFO_REMPTY & (tag_count != '0);

    assign bus.RFIFO_REN  = tag_pop;
    assign dbg_state      = state;
    assign dbg_tag_count  = tag_count;
    assign unused_rdata_msb = bus.RFIFO_RDATA[32];

    // Eligibility and winner selection; the pointer only matters on a tie.
    always_comb begin
        elig0 = bus.M0_REQ & ~bus.CFIFO_WFULL &
                (bus.M0_WRITE ? ~bus.WFIFO_WFULL : ~tag_full);
        elig1 = bus.M1_REQ & ~bus.CFIFO_WFULL &
                (bus.M1_WRITE ? ~bus.WFIFO_WFULL : ~tag_full);
        win   = (elig0 & elig1) ? rr_ptr : elig1;
        if (win) begin
            win_write = bus.M1_WRITE;
            win_size  = bus.M1_SIZE;
            win_addr  = bus.M1_ADDR;
            win_wdata = bus.M1_WDATA;
        end else begin
            win_write = bus.M0_WRITE;
            win_size  = bus.M0_SIZE;
            win_addr  = bus.M0_ADDR;
            win_wdata = bus.M0_WDATA;
        end
    end

    // Issue FSM: latch the winner in IDLE so pushes and ACK are registered
    // and visible for exactly the ISSUE cycle.
    always_ff @(posedge SDRAM_CLK) begin
        if (!SDRAM_RSTn) begin
            state           <= S_IDLE;
            rr_ptr          <= 1'b0;
            grant           <= 1'b0;
            cmd_write       <= 1'b0;
            bus.CFIFO_WEN   <= 1'b0;
            bus.CFIFO_WDATA <= '0;
            bus.WFIFO_WEN   <= 1'b0;
            bus.WFIFO_WDATA <= '0;
            bus.M0_ACK      <= 1'b0;
            bus.M1_ACK      <= 1'b0;
        end else begin
            bus.CFIFO_WEN <= 1'b0;
            bus.WFIFO_WEN <= 1'b0;
            bus.M0_ACK    <= 1'b0;
            bus.M1_ACK    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (elig0 | elig1) begin
                        grant           <= win;
                        cmd_write       <= win_write;
                        bus.CFIFO_WDATA <= {win_write, win_size, win_addr};
                        bus.WFIFO_WDATA <= {1'b0, win_wdata};
                        bus.CFIFO_WEN   <= 1'b1;
                        bus.WFIFO_WEN   <= win_write;
                        bus.M0_ACK      <= ~win;
                        bus.M1_ACK      <= win;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rr_ptr <= ~grant;
                    state  <= S_HOLD;
                end
                S_HOLD: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag queue: circular buffer of requester ids for outstanding reads.
    always_ff @(posedge SDRAM_CLK) begin
        if (!SDRAM_RSTn) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_count  <= '0;
        end else begin
            if (tag_push) begin
                tag_mem[tag_wr_ptr] <= grant;
                tag_wr_ptr          <= tag_wr_ptr + 1'b1;
            end
            if (tag_pop) begin
                tag_rd_ptr <= tag_rd_ptr + 1'b1;
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: tag_count <= tag_count;
            endcase
        end
    end

    // Read return: steer each popped entry to the requester named by the head
    // tag; the other requester's RDATA keeps its last value.
    always_ff @(posedge SDRAM_CLK) begin
        if (!SDRAM_RSTn) begin
            bus.M0_RVALID <= 1'b0;
            bus.M1_RVALID <= 1'b0;
            bus.M0_RDATA  <= '0;
            bus.M1_RDATA  <= '0;
        end else begin
            bus.M0_RVALID <= tag_pop & ~tag_head;
            bus.M1_RVALID <= tag_pop & tag_head;
            if (tag_pop & ~tag_head) begin
                bus.M0_RDATA <= bus.RFIFO_RDATA[31:0];
            end
            if (tag_pop & tag_head) begin
                bus.M1_RDATA <= bus.RFIFO_RDATA[31:0];
            end
        end
    end

endmodule

// File: tb/tb_mfp_sdram_arb.sv
// Bench for mfp_sdram_arb: directed requester stimulus, a show-ahead read FIFO
// model, and a monitor that checks every push and read return against
// expected queues filled when the stimulus is issued.
module tb_mfp_sdram_arb;

    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;
    logic [2:0] dbg_tag_count;

    int checks;
    int errors;

    mfp_sdram_arb_if bus ();

    mfp_sdram_arb #(.TAG_DEPTH(4), .TAG_AW(2)) dut (
        .SDRAM_CLK     (clk),
        .SDRAM_RSTn    (rst_n),
        .bus           (bus),
        .dbg_state     (dbg_state),
        .dbg_tag_count (dbg_tag_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [35:0] exp_cmd_q[$];
    logic        exp_ack_q[$];
    logic [32:0] exp_wd_q[$];
    logic [32:0] exp_rd_q[$];

    logic [31:0] rf_q[$];
    logic [31:0] rf_in_q[$];
    logic        rf_flush;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- read-data FIFO model ----------------
    initial begin
        logic ren_s;
        rf_flush         = 1'b0;
        bus.RFIFO_REMPTY = 1'b1;
        bus.RFIFO_RDATA  = '0;
        forever begin
            @(posedge clk);
            ren_s = bus.RFIFO_REN;
            #1;
            if (ren_s && rf_q.size() > 0) void'(rf_q.pop_front());
            if (rf_flush) begin
                rf_q.delete();
                rf_flush = 1'b0;
            end
            while (rf_in_q.size() > 0) rf_q.push_back(rf_in_q.pop_front());
            bus.RFIFO_REMPTY = (rf_q.size() == 0);
            bus.RFIFO_RDATA  = (rf_q.size() > 0) ? {1'b0, rf_q[0]} : 33'h0;
        end
    end

    // ---------------- monitor ----------------
    logic [35:0] m_cmd;
    logic        m_id;
    logic [32:0] m_exp;

    always @(negedge clk) begin
        if (bus.CFIFO_WEN) begin
            chk("cmd_expected", 64'(exp_cmd_q.size() != 0), 64'd1);
            if (exp_cmd_q.size() != 0) begin
                m_cmd = exp_cmd_q.pop_front();
                m_id  = exp_ack_q.pop_front();
                chk("cfifo_wdata", 64'(bus.CFIFO_WDATA), 64'(m_cmd));
                chk("ack_vec", 64'({bus.M1_ACK, bus.M0_ACK}), m_id ? 64'd2 : 64'd1);
                chk("wfifo_wen", 64'(bus.WFIFO_WEN), 64'(m_cmd[35]));
                if (bus.WFIFO_WEN && exp_wd_q.size() != 0) begin
                    m_exp = exp_wd_q.pop_front();
                    chk("wfifo_wdata", 64'(bus.WFIFO_WDATA), 64'(m_exp));
                end
            end
        end else begin
            chk("idle_no_ack_no_wpush", 64'({bus.M1_ACK, bus.M0_ACK, bus.WFIFO_WEN}), 64'd0);
        end
        if (bus.M0_RVALID || bus.M1_RVALID) begin
            chk("rvalid_onehot", 64'(bus.M0_RVALID & bus.M1_RVALID), 64'd0);
            chk("rd_expected", 64'(exp_rd_q.size() != 0), 64'd1);
            if (exp_rd_q.size() != 0) begin
                m_exp = exp_rd_q.pop_front();
                chk("rd_return",
                    64'({bus.M1_RVALID, bus.M1_RVALID ? bus.M1_RDATA : bus.M0_RDATA}),
                    64'(m_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic id, input logic req, input logic wr,
                           input logic [2:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd);
        if (!id) begin
            bus.M0_REQ = req; bus.M0_WRITE = wr; bus.M0_SIZE = sz;
            bus.M0_ADDR = addr; bus.M0_WDATA = wd;
        end else begin
            bus.M1_REQ = req; bus.M1_WRITE = wr; bus.M1_SIZE = sz;
            bus.M1_ADDR = addr; bus.M1_WDATA = wd;
        end
    endtask

    task automatic expect_cmd(input logic id, input logic [35:0] cmd, input logic [31:0] wd);
        exp_cmd_q.push_back(cmd);
        exp_ack_q.push_back(id);
        if (cmd[35]) exp_wd_q.push_back({1'b0, wd});
    endtask

    task automatic wait_ack(input logic id, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = id ? bus.M1_ACK : bus.M0_ACK;
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    task automatic issue_one(input logic id, input logic wr, input logic [2:0] sz,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [35:0] cmd);
        expect_cmd(id, cmd, wd);
        set_req(id, 1'b1, wr, sz, addr, wd);
        wait_ack(id, "issue_ack");
        set_req(id, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic push_rdata(input logic id, input logic [31:0] d);
        rf_in_q.push_back(d);
        exp_rd_q.push_back({id, d});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        logic rv_seen;
        logic ack_seen;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.CFIFO_WFULL = 1'b0;
        bus.WFIFO_WFULL = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        chk("rst_cfifo", 64'({bus.CFIFO_WEN, bus.CFIFO_WDATA}), 64'd0);
        chk("rst_wfifo", 64'({bus.WFIFO_WEN, bus.WFIFO_WDATA}), 64'd0);
        chk("rst_acks_rvalids", 64'({bus.M0_ACK, bus.M1_ACK, bus.M0_RVALID, bus.M1_RVALID}), 64'd0);
        chk("rst_rdata", {bus.M1_RDATA, bus.M0_RDATA}, 64'd0);
        chk("rst_ren", 64'(bus.RFIFO_REN), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        chk("rst_tags", 64'(dbg_tag_count), 64'd0);

        // Both reading continuously: M0, M1, M0, M1, one ACK every 3 cycles
        expect_cmd(1'b0, 36'h2_0000_0200, 32'h0);
        expect_cmd(1'b1, 36'h1_0000_0300, 32'h0);
        expect_cmd(1'b0, 36'h2_0000_0200, 32'h0);
        expect_cmd(1'b1, 36'h1_0000_0300, 32'h0);
        set_req(1'b0, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 3'b001, 32'h300, 32'h0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("ack_cadence", 64'(bus.M0_ACK | bus.M1_ACK), 64'((c % 3) == 1));
        end
        set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("alt_tag_count", 64'(dbg_tag_count), 64'd4);
        push_rdata(1'b0, 32'h1000_0000);
        push_rdata(1'b1, 32'h1000_0001);
        push_rdata(1'b0, 32'h1000_0002);
        push_rdata(1'b1, 32'h1000_0003);
        repeat (8) @(negedge clk);
        chk("alt_drained", 64'(dbg_tag_count), 64'd0);

        // Single M0 write: ACK one cycle after REQ, both FIFOs pushed together
        expect_cmd(1'b0, 36'hA_0000_0100, 32'hDEAD_BEEF);
        set_req(1'b0, 1'b1, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("m0_ack_latency", 64'(bus.M0_ACK), 64'd1);
        chk("m1_ack_quiet", 64'(bus.M1_ACK), 64'd0);
        set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Fill the tag queue with M1 reads; writes still pass, reads stall
        for (int i = 0; i < 4; i++)
            issue_one(1'b1, 1'b0, 3'b010, 32'h400 + 32'(4 * i), 32'h0, 36'h2_0000_0400 + 36'(4 * i));
        chk("tags_full", 64'(dbg_tag_count), 64'd4);
        expect_cmd(1'b0, 36'hA_0000_0500, 32'hCAFE_F00D);
        expect_cmd(1'b1, 36'h2_0000_0410, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 3'b010, 32'h410, 32'h0);
        set_req(1'b0, 1'b1, 1'b1, 3'b010, 32'h500, 32'hCAFE_F00D);
        wait_ack(1'b0, "m0_write_past_full_tags");
        set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cnt += int'(bus.M1_ACK);
        end
        chk("m1_blocked", 64'(cnt), 64'd0);
        push_rdata(1'b1, 32'h1234_5678);
        rv_seen  = 1'b0;
        ack_seen = 1'b0;
        for (int c = 0; c < 20 && !ack_seen; c++) begin
            @(negedge clk);
            if (bus.M1_RVALID) rv_seen = 1'b1;
            ack_seen = bus.M1_ACK;
        end
        chk("m1_fifth_ack", 64'(ack_seen), 64'd1);
        chk("rvalid_before_ack", 64'(rv_seen), 64'd1);
        set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) push_rdata(1'b1, 32'h2000_0000 + 32'(i));
        repeat (8) @(negedge clk);
        chk("full_test_drained", 64'(dbg_tag_count), 64'd0);

        // Command FIFO full: nothing moves; on release M0 wins first
        bus.CFIFO_WFULL = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 3'b000, 32'h600, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 3'b010, 32'h700, 32'h0);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cnt += int'(bus.M0_ACK | bus.M1_ACK | bus.CFIFO_WEN | bus.WFIFO_WEN);
        end
        chk("cfifo_full_stall", 64'(cnt), 64'd0);
        expect_cmd(1'b0, 36'h0_0000_0600, 32'h0);
        expect_cmd(1'b1, 36'h2_0000_0700, 32'h0);
        bus.CFIFO_WFULL = 1'b0;
        wait_ack(1'b0, "m0_first_after_full");
        set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        wait_ack(1'b1, "m1_after_full");
        set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        issue_one(1'b0, 1'b0, 3'b001, 32'h800, 32'h0, 36'h1_0000_0800);

        // Interleaved returns for tags M0, M1, M0
        chk("interleave_tags", 64'(dbg_tag_count), 64'd3);
        push_rdata(1'b0, 32'h0000_000A);
        push_rdata(1'b1, 32'h0000_000B);
        push_rdata(1'b0, 32'h0000_000C);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("ren_burst", 64'(bus.RFIFO_REN), 64'(c <= 3));
            chk("rvalid_seq", 64'({bus.M1_RVALID, bus.M0_RVALID}),
                (c == 1) ? 64'd0 : (c == 3) ? 64'd2 : 64'd1);
            if (c == 3) chk("m0_rdata_hold", 64'(bus.M0_RDATA), 64'h0A);
            if (c == 4) chk("m1_rdata_hold", 64'(bus.M1_RDATA), 64'h0B);
        end

        // Reset during ISSUE with two reads outstanding
        issue_one(1'b0, 1'b0, 3'b010, 32'h900, 32'h0, 36'h2_0000_0900);
        issue_one(1'b0, 1'b0, 3'b010, 32'h904, 32'h0, 36'h2_0000_0904);
        expect_cmd(1'b1, 36'h8_0000_0A00, 32'h5A5A_5A5A);
        set_req(1'b1, 1'b1, 1'b1, 3'b000, 32'hA00, 32'h5A5A_5A5A);
        wait_ack(1'b1, "m1_write_before_reset");
        rst_n = 1'b0;
        rf_in_q.push_back(32'h0000_0055);
        set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("mid_rst_cfifo", 64'({bus.CFIFO_WEN, bus.CFIFO_WDATA}), 64'd0);
        chk("mid_rst_wfifo", 64'({bus.WFIFO_WEN, bus.WFIFO_WDATA}), 64'd0);
        chk("mid_rst_acks_rvalids", 64'({bus.M0_ACK, bus.M1_ACK, bus.M0_RVALID, bus.M1_RVALID}), 64'd0);
        chk("mid_rst_rdata", {bus.M1_RDATA, bus.M0_RDATA}, 64'd0);
        chk("mid_rst_rfifo_nonempty", 64'(bus.RFIFO_REMPTY), 64'd0);
        chk("mid_rst_ren", 64'(bus.RFIFO_REN), 64'd0);
        chk("mid_rst_tags", 64'(dbg_tag_count), 64'd0);
        chk("mid_rst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ren", 64'(bus.RFIFO_REN), 64'd0);
        rf_flush = 1'b1;
        @(negedge clk);
        expect_cmd(1'b0, 36'h2_0000_0B00, 32'h0);
        expect_cmd(1'b1, 36'h2_0000_0B04, 32'h0);
        set_req(1'b0, 1'b1, 1'b0, 3'b010, 32'hB00, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 3'b010, 32'hB04, 32'h0);
        wait_ack(1'b0, "m0_first_after_reset");
        set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        wait_ack(1'b1, "m1_after_reset");
        set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        push_rdata(1'b0, 32'h3000_0000);
        push_rdata(1'b1, 32'h3000_0001);
        repeat (6) @(negedge clk);

        // Final report
        chk("left_cmd", 64'(exp_cmd_q.size()), 64'd0);
        chk("left_wdata", 64'(exp_wd_q.size()), 64'd0);
        chk("left_rdata", 64'(exp_rd_q.size()), 64'd0);
        chk("left_tags", 64'(dbg_tag_count), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
